dec_unbinder_seq: RTL and testbench

DEC_UNBINDER_SEQ -- requirements
Module: dec_unbinder_seq

---
 rtl/dec_unbinder_seq_pkg.sv | 35 +++
 rtl/dec_unbinder_seq_hv_rotr.sv | 15 +
 rtl/dec_unbinder_seq.sv | 123 ++++++++++++
 tb/tb_dec_unbinder_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_unbinder_seq_pkg.sv
// Shared hypervector definitions: vector width, the per-channel shift table
// used by the encoder binders and this unbinder, and the unbinder FSM states.
package dec_unbinder_seq_pkg;

  localparam int unsigned HV_DIM     = 64;
  localparam int unsigned NUM_SHIFTS = 512;

  // Permutation amounts per binding slot. Entries may be >= HV_DIM; every
  // user reduces them modulo the vector width before rotating.
  localparam int unsigned SHIFTS [NUM_SHIFTS] = '{
    420: 3,
    421: 17,
    422: 0,
    423: 64,
    424: 70,
    425: 1,
    426: 63,
    427: 31,
    428: 200,
    429: 45,
    default: 0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_FINISH = 2'd2
  } dec_state_e;

  // Reduce a table shift to the range [0, dim).
  function automatic int unsigned shift_mod(input int unsigned s, input int unsigned dim);
    return s % dim;
  endfunction

endpackage

// File: rtl/dec_unbinder_seq_hv_rotr.sv
// Combinational right rotation of a hypervector: rot[j] = hv[(j+shift) mod HV_DIM].
// The caller guarantees shift < HV_DIM.
module hv_rotr #(
  parameter int unsigned HV_DIM = 64,
  parameter int unsigned SH_W   = $clog2(HV_DIM)
) (
  input  logic [HV_DIM-1:0] hv,
  input  logic [SH_W-1:0]   shift,
  output logic [HV_DIM-1:0] rot
);

  // A left shift by HV_DIM yields zero, so shift 0 passes hv unchanged.
  assign rot = (hv >> shift) | (hv << (HV_DIM - shift));

endmodule

// File: rtl/dec_unbinder_seq.sv
// Sequential unbinder: captures one bound query and emits it rotated right by
// each channel's shift, one channel per handshake, through a single rotator.
//
// Handshake: a result transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, with out_idx
// and unbound_hv held, until that transfer happens; out_ready is a don't-care
// while out_valid is low.
module dec_unbinder_seq #(
  parameter int unsigned HV_DIM = dec_unbinder_seq_pkg::HV_DIM,
  parameter int unsigned NUM_CH = 10,
  parameter int unsigned BASE   = 420,
  parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic [HV_DIM-1:0] bound_hv,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic [HV_DIM-1:0] unbound_hv,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  import dec_unbinder_seq_pkg::*;

  localparam int unsigned SH_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  dec_state_e        state, state_nxt;
  logic [HV_DIM-1:0] query_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [HV_DIM-1:0] rot_src, rot_out;
  logic [IDX_W-1:0]  sel_idx;
  logic [SH_W-1:0]   sel_shift;
  logic              accept, advance;

  // Next state, and which query/channel feeds the rotator this cycle.
  // In IDLE the rotator looks at the live input so channel 0 is ready one
  // cycle after start; afterwards it works on the captured query.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    rot_src   = query_q;
    sel_idx   = cnt_q + IDX_W'(1);
    case (state)
      ST_IDLE: begin
        rot_src = bound_hv;
        sel_idx = '0;
        if (start_decoding) begin
          accept    = 1'b1;
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_nxt = ST_FINISH;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Shift mux over this block's slice of the table; its result is captured
  // in unbound_hv through the one shared rotator.
  always_comb begin
    sel_shift = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_shift = SH_W'(shift_mod(SHIFTS[BASE + i], HV_DIM));
      end
    end
  end

  hv_rotr #(
    .HV_DIM (HV_DIM),
    .SH_W   (SH_W)
  ) u_rotr (
    .hv    (rot_src),
    .shift (sel_shift),
    .rot   (rot_out)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Query capture, channel counter and registered result.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      query_q    <= '0;
      cnt_q      <= '0;
      unbound_hv <= '0;
    end else if (accept) begin
      query_q    <= bound_hv;
      cnt_q      <= '0;
      unbound_hv <= rot_out;
    end else if (advance) begin
      cnt_q      <= cnt_q + IDX_W'(1);
      unbound_hv <= rot_out;
    end
  end

  assign out_valid = (state == ST_EMIT);
  assign busy      = (state == ST_EMIT);
  assign done      = (state == ST_FINISH);
  assign out_idx   = cnt_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Testbench for dec_unbinder_seq: randomized queries checked against a
// rotation model computed directly from the bit-index definition.
module tb_dec_unbinder_seq;

  localparam int unsigned N     = dec_unbinder_seq_pkg::HV_DIM;
  localparam int unsigned NCH   = 10;
  localparam int unsigned BASE  = 420;
  localparam int unsigned IDX_W = $clog2(NCH);

  logic             clk = 1'b0;
  logic             nrst;
  logic             start_decoding;
  logic [N-1:0]     bound_hv;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     unbound_hv;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  int n_chk  = 0;
  int n_fail = 0;
  logic [N-1:0] exp_q[$];

  dec_unbinder_seq #(.HV_DIM(N), .NUM_CH(NCH), .BASE(BASE)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_decoding (start_decoding),
    .bound_hv       (bound_hv),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_idx        (out_idx),
    .unbound_hv     (unbound_hv),
    .busy           (busy),
    .done           (done),
    .state_dbg      (state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model: out[j] = q[(j+s) mod N]; encoder is the mirror image.
  function automatic logic [N-1:0] rotr_m(input logic [N-1:0] q, input int unsigned s);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = q[(j + s) % N];
    return r;
  endfunction

  function automatic logic [N-1:0] rotl_m(input logic [N-1:0] q, input int unsigned s);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[(j + s) % N] = q[j];
    return r;
  endfunction

  function automatic logic [N-1:0] rand_hv();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Driver tasks
  task automatic load_exp(input logic [N-1:0] q);
    exp_q.delete();
    for (int i = 0; i < NCH; i++) exp_q.push_back(rotr_m(q, dec_unbinder_seq_pkg::SHIFTS[BASE + i]));
  endtask

  // Returns at the negedge right after the start edge (first result visible).
  task automatic do_start(input logic [N-1:0] q);
    @(negedge clk);
    start_decoding = 1'b1;
    bound_hv       = q;
    @(negedge clk);
    start_decoding = 1'b0;
    bound_hv       = rand_hv();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    nrst = 1'b0; start_decoding = 1'b1; bound_hv = rand_hv(); out_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_chk++; if (out_idx !== '0) begin n_fail++; $display("FAIL rst_idx got=%0d exp=0", out_idx); end
    n_chk++; if (unbound_hv !== '0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", unbound_hv); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
    nrst = 1'b1; start_decoding = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_start_discard got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_bit();
    logic [N-1:0] q, e;
    q = '0; q[5] = 1'b1;
    e = '0; e[2] = 1'b1;
    out_ready = 1'b1;
    do_start(q);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid got=%b exp=1", out_valid); end
    n_chk++; if (out_idx !== '0) begin n_fail++; $display("FAIL sb_idx got=%0d exp=0", out_idx); end
    n_chk++; if (unbound_hv !== e) begin n_fail++; $display("FAIL sb_data got=%h exp=%h", unbound_hv, e); end
    drain();
  endtask

  task automatic test_round_trip();
    logic [N-1:0] level;
    for (int ch = 0; ch < NCH; ch++) begin
      level = rand_hv();
      out_ready = 1'b1;
      do_start(rotl_m(level, dec_unbinder_seq_pkg::SHIFTS[BASE + ch]));
      repeat (ch) @(negedge clk);
      n_chk++; if (out_idx !== IDX_W'(ch)) begin n_fail++; $display("FAIL rt_idx ch=%0d got=%0d exp=%0d", ch, out_idx, ch); end
      n_chk++; if (unbound_hv !== level) begin n_fail++; $display("FAIL rt_data ch=%0d got=%h exp=%h", ch, unbound_hv, level); end
      drain();
    end
  endtask

  task automatic test_throughput();
    logic [N-1:0] q;
    int dn;
    q = rand_hv(); load_exp(q); out_ready = 1'b1; dn = 0;
    do_start(q);
    for (int c = 0; c < 13; c++) begin
      if (c < NCH) begin
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL thr_valid c=%0d got=%b exp=1", c, out_valid); end
        n_chk++; if (out_idx !== IDX_W'(c)) begin n_fail++; $display("FAIL thr_idx c=%0d got=%0d exp=%0d", c, out_idx, c); end
        n_chk++; if (unbound_hv !== exp_q[c]) begin n_fail++; $display("FAIL thr_data c=%0d got=%h exp=%h", c, unbound_hv, exp_q[c]); end
      end else begin
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL thr_valid_end c=%0d got=%b exp=0", c, out_valid); end
      end
      if (c == NCH) begin
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL thr_done got=%b exp=1", done); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL thr_busy got=%b exp=0", busy); end
      end
      if (done) dn++;
      @(negedge clk);
    end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL thr_done_count got=%0d exp=1", dn); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] q, snap;
    int exp_idx, hs, dn, stall;
    q = rand_hv(); load_exp(q); out_ready = 1'b1;
    exp_idx = 0; hs = 0; dn = 0; stall = 0; snap = '0;
    do_start(q);
    for (int c = 0; c < 30; c++) begin
      if (done) dn++;
      out_ready = 1'b1;
      if (out_valid) begin
        if (exp_idx < NCH) begin
          n_chk++; if (out_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL bp_idx got=%0d exp=%0d", out_idx, exp_idx); end
          n_chk++; if (unbound_hv !== exp_q[exp_idx]) begin n_fail++; $display("FAIL bp_data idx=%0d got=%h exp=%h", exp_idx, unbound_hv, exp_q[exp_idx]); end
        end else begin
          n_chk++; n_fail++; $display("FAIL bp_extra_valid got=%0d results exp=%0d", exp_idx + 1, NCH);
        end
        if (exp_idx == 3 && stall < 4) begin
          if (stall == 0) snap = unbound_hv;
          else begin
            n_chk++; if (unbound_hv !== snap) begin n_fail++; $display("FAIL bp_stable stall=%0d got=%h exp=%h", stall, unbound_hv, snap); end
          end
          out_ready = 1'b0;
          stall++;
        end
      end
      if (out_valid && out_ready) begin hs++; exp_idx++; end
      @(negedge clk);
    end
    n_chk++; if (hs != NCH) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=%0d", hs, NCH); end
    n_chk++; if (dn != 1) begin n_fail++; $display("FAIL bp_done_count got=%0d exp=1", dn); end
    n_chk++; if (stall != 4) begin n_fail++; $display("FAIL bp_stall_cycles got=%0d exp=4", stall); end
  endtask

  task automatic test_random();
    logic [N-1:0] q;
    int exp_idx, hs, dn;
    for (int t = 0; t < 5; t++) begin
      q = rand_hv(); load_exp(q);
      exp_idx = 0; hs = 0; dn = 0;
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_start(q);
      for (int c = 0; c < 80; c++) begin
        if (done) dn++;
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid) begin
          if (exp_idx < NCH) begin
            n_chk++; if (out_idx !== IDX_W'(exp_idx)) begin n_fail++; $display("FAIL rnd_idx t=%0d got=%0d exp=%0d", t, out_idx, exp_idx); end
            n_chk++; if (unbound_hv !== exp_q[exp_idx]) begin n_fail++; $display("FAIL rnd_data t=%0d idx=%0d got=%h exp=%h", t, exp_idx, unbound_hv, exp_q[exp_idx]); end
          end else begin
            n_chk++; n_fail++; $display("FAIL rnd_extra_valid t=%0d got=%0d results exp=%0d", t, exp_idx + 1, NCH);
          end
        end
        if (out_valid && out_ready) begin hs++; exp_idx++; end
        @(negedge clk);
      end
      n_chk++; if (hs != NCH) begin n_fail++; $display("FAIL rnd_handshakes t=%0d got=%0d exp=%0d", t, hs, NCH); end
      n_chk++; if (dn != 1) begin n_fail++; $display("FAIL rnd_done_count t=%0d got=%0d exp=1", t, dn); end
    end
  endtask

  task automatic test_ignore();
    logic [N-1:0] q;
    q = rand_hv(); load_exp(q); out_ready = 1'b1;
    do_start(q);
    for (int c = 0; c < 13; c++) begin
      if (c < NCH) begin
        n_chk++; if (out_idx !== IDX_W'(c)) begin n_fail++; $display("FAIL ign_idx c=%0d got=%0d exp=%0d", c, out_idx, c); end
        n_chk++; if (unbound_hv !== exp_q[c]) begin n_fail++; $display("FAIL ign_data c=%0d got=%h exp=%h", c, unbound_hv, exp_q[c]); end
      end
      if (c == NCH) begin
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done got=%b exp=1", done); end
      end
      if (c > NCH) begin
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_finish_start c=%0d got=%b exp=0", c, out_valid); end
      end
      start_decoding = (c == 6) || (c == NCH);
      bound_hv = rand_hv();
      @(negedge clk);
    end
    start_decoding = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] q, q2;
    int dn;
    q = rand_hv(); load_exp(q); out_ready = 1'b1; dn = 0;
    do_start(q);
    repeat (4) @(negedge clk);
    n_chk++; if (out_idx !== IDX_W'(4)) begin n_fail++; $display("FAIL rm_pre_idx got=%0d exp=4", out_idx); end
    nrst = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
    n_chk++; if (out_idx !== '0) begin n_fail++; $display("FAIL rm_idx got=%0d exp=0", out_idx); end
    n_chk++; if (unbound_hv !== '0) begin n_fail++; $display("FAIL rm_data got=%h exp=0", unbound_hv); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got=%b exp=0", busy); end
    nrst = 1'b1;
    repeat (4) begin
      if (done) dn++;
      @(negedge clk);
    end
    n_chk++; if (dn != 0) begin n_fail++; $display("FAIL rm_no_done got=%0d exp=0", dn); end
    q2 = rand_hv(); load_exp(q2);
    do_start(q2);
    n_chk++; if (out_idx !== '0) begin n_fail++; $display("FAIL rm_new_idx got=%0d exp=0", out_idx); end
    n_chk++; if (unbound_hv !== exp_q[0]) begin n_fail++; $display("FAIL rm_new_data got=%h exp=%h", unbound_hv, exp_q[0]); end
    drain();
  endtask

  // Test sequence and final report
  initial begin
    nrst = 1'b0; start_decoding = 1'b0; bound_hv = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_bit();
    test_round_trip();
    test_throughput();
    test_backpressure();
    test_random();
    test_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
